vc_dest_arbiter: RTL and testbench
==================================

Name: vc_dest_arbiter

Overview:
- Sits between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) in the PCIe transaction path.
- Each cycle it picks at most one VC head word, pops it, and pushes it to the destination selected by word bit [4].
- VC0 has fixed priority; a starvation counter guarantees VC1 progress.
- A small control FSM reports idle, active and error status to the logic master.

Parameters:
- DATA_W, 6: word width. Bit [5] = VC tag, bit [4] = destination (0 = D0, 1 = D1), bits [3:0] = payload.
- STARVE_MAX, 4: number of consecutive cycles VC1 may be eligible but not granted before it is forced.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- init  in  1  configuration request; while high, no grants are issued.
- vc0_empty  in  1  VC0 FIFO empty.
- vc1_empty  in  1  VC1 FIFO empty.
- vc0_data  in  DATA_W  VC0 head word (show-ahead FIFO).
- vc1_data  in  DATA_W  VC1 head word (show-ahead FIFO).
- d0_almost_full  in  1  D0 FIFO has at most 1 free slot.
- d1_almost_full  in  1  D1 FIFO has at most 1 free slot.
- d0_full  in  1  D0 FIFO full.
- d1_full  in  1  D1 FIFO full.
- vc0_pop  out  1  combinational pop of VC0.
- vc1_pop  out  1  combinational pop of VC1.
- d0_push  out  1  registered push to D0.
- d1_push  out  1  registered push to D1.
- data_out  out  DATA_W  registered word accompanying d0_push / d1_push.
- active_out  out  1  FSM is in ACTIVE.
- idle_out  out  1  FSM is in IDLE.
- error_out  out  1  FSM is in ERROR.

Behaviour:
- Reset (synchronous, active-high): FSM enters RESET. All pops and pushes are 0, data_out = 0, starvation counter = 0. Status outputs: idle_out = 0, active_out = 0, error_out = 0.
- FSM transitions:
  - RESET -> INIT on the first cycle after reset deasserts.
  - INIT -> IDLE when init = 0.
  - IDLE -> ACTIVE when either VC is non-empty.
  - ACTIVE -> IDLE when both VCs are empty and no push is in flight.
  - Any state except RESET -> INIT when init = 1.
  - ERROR is sticky; only reset exits it.
- Eligibility:
  - VCn is eligible when vcn_empty = 0 and the almost_full flag of the destination selected by vcn_data[4] is 0.
  - Grants are issued only in ACTIVE.
- Grant rule: VC0 is granted if eligible. The exception: if VC1 is eligible and the starvation counter equals STARVE_MAX, VC1 is granted.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each cycle VC1 is eligible but not granted.
  - Clears when VC1 is granted or VC1 is not eligible.
- Pop: vcn_pop is asserted in the same cycle as the grant. At most one pop per cycle.
- Push latency is 1 cycle: the next edge registers data_out = the granted word and asserts d0_push or d1_push according to bit [4]. At most one push per cycle.
- Back-to-back grants are allowed every cycle. The almost_full slack covers the single in-flight push.
- Error condition: if dN_push would be asserted while dN_full = 1, the push is suppressed, the FSM enters ERROR and error_out = 1. In ERROR all pops and pushes are 0.
- init asserted mid-transfer: the already-registered push still completes; no new grant is issued in that cycle or later until init drops.
- Reset mid-transfer: the pending push is discarded.

Decomposition:
- Shared package pcie_trans_pkg:
  - FSM state encoding (RESET, INIT, IDLE, ACTIVE, ERROR).
  - Bit-index constants: VC_BIT = 5, DEST_BIT = 4.
  - Default DATA_W.
- One sub-module is natural: vc_starve_ctr, holding the saturating counter and the force flag.

Test Plan:
- Reset, then init pulse, then both VCs empty -> idle_out = 1, all pops and pushes 0.
- VC0 head 0x1B, VC1 empty, D1 not almost full -> vc0_pop = 1 in cycle t; d1_push = 1 and data_out = 0x1B in cycle t+1; active_out = 1.
- VC0 continuously eligible and VC1 holding 0x2D (destination D0) -> four VC0 grants, then a VC1 grant on the fifth cycle with d0_push and data_out = 0x2D; counter returns to 0.
- VC0 head 0x1A with d1_almost_full = 1, VC1 head 0x2D with D0 free -> VC1 is granted (VC0 not eligible); VC0 is granted once almost_full drops.
- Force d0_full = 1 while a push to D0 is in flight -> d0_push suppressed, error_out = 1 and stays high until reset.
- Assert init while traffic flows -> the in-flight push completes, no new pops, FSM in INIT; on release the FSM goes IDLE then ACTIVE.

Source files
------------

// File: rtl/pcie_trans_pkg.sv
// Shared definitions for the PCIe transaction-path VC/destination arbiter.
package pcie_trans_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int VC_BIT     = 5;
  localparam int DEST_BIT   = 4;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } arb_state_e;

  function automatic logic word_dest(input logic [DATA_W_DEF-1:0] w);
    return w[DEST_BIT];
  endfunction

  function automatic logic word_vc(input logic [DATA_W_DEF-1:0] w);
    return w[VC_BIT];
  endfunction

endpackage

// File: rtl/vc_starve_ctr.sv
// Saturating starvation counter for VC1; raises force when VC1 has waited
// STARVE_MAX consecutive eligible cycles without a grant.
module vc_starve_ctr #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic elig_i,
  input  logic grant_i,
  output logic force_o
);

  localparam logic [CNT_W-1:0] MaxC = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count eligible-but-denied cycles, saturate at the limit, clear otherwise.
  always_comb begin
    cnt_d = '0;
    if (elig_i && !grant_i) begin
      cnt_d = (cnt_q == MaxC) ? MaxC : cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign force_o = elig_i && (cnt_q == MaxC);

endmodule

// File: rtl/vc_dest_arbiter.sv
// Picks one VC head word per cycle (VC0 priority, VC1 starvation-protected),
// pops it and pushes it one cycle later to the destination chosen by bit 4.
//
// state  | meaning
// RESET  | held in reset, everything quiet
// INIT   | configuration in progress, no grants
// IDLE   | both VCs empty, waiting for traffic
// ACTIVE | grants issued each cycle an eligible VC exists
// ERROR  | push attempted into a full destination; sticky until reset
module vc_dest_arbiter
  import pcie_trans_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  input  logic              d0_full,
  input  logic              d1_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic              d0_push,
  output logic              d1_push,
  output logic [DATA_W-1:0] data_out,
  output logic              active_out,
  output logic              idle_out,
  output logic              error_out
);

  arb_state_e        state_q, state_d;
  logic              grant_en, vc0_elig, vc1_elig, vc0_grant, vc1_grant, vc1_force;
  logic              any_grant, grant_dest, push0_d, push1_d, push_err;
  logic [DATA_W-1:0] grant_word;
  logic              d0_push_q, d1_push_q;
  logic [DATA_W-1:0] data_out_q;
  logic              idle_q, active_q, error_q;

  // Eligibility looks at the almost-full flag of the head word's destination;
  // the one-slot slack absorbs the push that is still in flight.
  assign grant_en = (state_q == ST_ACTIVE) && !init;
  assign vc0_elig = grant_en && !vc0_empty &&
                    !(vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
  assign vc1_elig = grant_en && !vc1_empty &&
                    !(vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full);

  assign vc1_grant  = vc1_elig && (vc1_force || !vc0_elig);
  assign vc0_grant  = vc0_elig && !vc1_grant;
  assign any_grant  = vc0_grant || vc1_grant;
  assign grant_word = vc1_grant ? vc1_data : vc0_data;
  assign grant_dest = grant_word[DEST_BIT];
  assign push0_d    = any_grant && !grant_dest;
  assign push1_d    = any_grant && grant_dest;
  assign push_err   = (push0_d && d0_full) || (push1_d && d1_full);

  vc_starve_ctr #(
    .STARVE_MAX(STARVE_MAX),
    .CNT_W     (CNT_W)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .elig_i (vc1_elig),
    .grant_i(vc1_grant),
    .force_o(vc1_force)
  );

  // Next-state selection; ERROR ignores init so only reset can clear it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_ERROR: state_d = ST_ERROR;
      default: begin
        if (init) begin
          state_d = ST_INIT;
        end else if (push_err) begin
          state_d = ST_ERROR;
        end else begin
          case (state_q)
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE:   if (!vc0_empty || !vc1_empty) state_d = ST_ACTIVE;
            ST_ACTIVE: if (vc0_empty && vc1_empty && !d0_push_q && !d1_push_q)
                         state_d = ST_IDLE;
            default:   state_d = ST_ERROR;
          endcase
        end
      end
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RESET;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= (state_d == ST_IDLE);
      active_q <= (state_d == ST_ACTIVE);
      error_q  <= (state_d == ST_ERROR);
    end
  end

  // Registered push stage; a push into a full destination is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      d0_push_q  <= 1'b0;
      d1_push_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      d0_push_q <= push0_d && !d0_full;
      d1_push_q <= push1_d && !d1_full;
      if (any_grant) data_out_q <= grant_word;
    end
  end

  assign vc0_pop    = vc0_grant;
  assign vc1_pop    = vc1_grant;
  assign d0_push    = d0_push_q;
  assign d1_push    = d1_push_q;
  assign data_out   = data_out_q;
  assign idle_out   = idle_q;
  assign active_out = active_q;
  assign error_out  = error_q;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Directed bench for vc_dest_arbiter with a push scoreboard.
module tb_vc_dest_arbiter;

  logic       clk = 1'b0;
  logic       reset, init;
  logic       vc0_empty, vc1_empty;
  logic [5:0] vc0_data, vc1_data;
  logic       d0_almost_full, d1_almost_full, d0_full, d1_full;
  logic       vc0_pop, vc1_pop, d0_push, d1_push;
  logic [5:0] data_out;
  logic       active_out, idle_out, error_out;

  int tests  = 0;
  int failed = 0;
  logic [5:0] sb[$];

  vc_dest_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .vc0_empty     (vc0_empty),
    .vc1_empty     (vc1_empty),
    .vc0_data      (vc0_data),
    .vc1_data      (vc1_data),
    .d0_almost_full(d0_almost_full),
    .d1_almost_full(d1_almost_full),
    .d0_full       (d0_full),
    .d1_full       (d1_full),
    .vc0_pop       (vc0_pop),
    .vc1_pop       (vc1_pop),
    .d0_push       (d0_push),
    .d1_push       (d1_push),
    .data_out      (data_out),
    .active_out    (active_out),
    .idle_out      (idle_out),
    .error_out     (error_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Every observed push must match the oldest expected word and its destination.
  always @(negedge clk) begin
    if (d0_push === 1'b1 || d1_push === 1'b1) begin
      if (sb.size() == 0) begin
        check("push_unexpected", {30'd0, d1_push, d0_push}, 32'd0);
      end else begin
        logic [5:0] w;
        w = sb.pop_front();
        check("push_data", {26'd0, data_out}, {26'd0, w});
        check("push_dest", {30'd0, d1_push, d0_push}, w[4] ? 32'd2 : 32'd1);
      end
    end
  end

  initial begin
    reset = 1'b1; init = 1'b0;
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    vc0_data = '0; vc1_data = '0;
    d0_almost_full = 1'b0; d1_almost_full = 1'b0;
    d0_full = 1'b0; d1_full = 1'b0;
    tick(); tick();
    check("reset_outs", {26'd0, d0_push, d1_push, idle_out, active_out, error_out, |data_out}, 32'd0);

    // reset release, init pulse, then idle with empty VCs
    reset = 1'b0; init = 1'b1;
    tick();
    check("init_status", {29'd0, idle_out, active_out, error_out}, 32'd0);
    tick();
    init = 1'b0;
    tick();
    check("idle_after_init", {31'd0, idle_out}, 32'd1);
    settle();
    check("idle_quiet", {28'd0, vc0_pop, vc1_pop, d0_push, d1_push}, 32'd0);

    // single VC0 word to D1
    tick();
    vc0_empty = 1'b0; vc0_data = 6'h1B;
    settle();
    check("idle_no_pop", {30'd0, vc0_pop, vc1_pop}, 32'd0);
    tick();
    check("active_up", {31'd0, active_out}, 32'd1);
    settle();
    check("vc0_pop_1b", {30'd0, vc0_pop, vc1_pop}, 32'd2);
    sb.push_back(6'h1B);
    tick();
    check("active_push", {31'd0, active_out}, 32'd1);
    vc0_empty = 1'b1;
    tick(); tick(); tick();
    check("back_idle_1", {31'd0, idle_out}, 32'd1);

    // starvation: four VC0 grants then a forced VC1 grant, twice
    vc0_empty = 1'b0; vc1_empty = 1'b0; vc1_data = 6'h2D; vc0_data = 6'h00;
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        vc0_data = (r == 0) ? 6'(i) : 6'(6'h10 | i);
        settle();
        check("starve_vc0", {30'd0, vc0_pop, vc1_pop}, 32'd2);
        sb.push_back(vc0_data);
        tick();
      end
      settle();
      check("starve_vc1", {30'd0, vc0_pop, vc1_pop}, 32'd1);
      sb.push_back(vc1_data);
      tick();
      vc1_data = 6'h3E;
    end
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    tick(); tick(); tick();
    check("back_idle_2", {31'd0, idle_out}, 32'd1);

    // VC0 blocked by almost_full, VC1 goes first
    vc0_empty = 1'b0; vc0_data = 6'h1A; d1_almost_full = 1'b1;
    vc1_empty = 1'b0; vc1_data = 6'h2D;
    tick();
    settle();
    check("af_vc1_first", {30'd0, vc0_pop, vc1_pop}, 32'd1);
    sb.push_back(6'h2D);
    tick();
    vc1_empty = 1'b1; d1_almost_full = 1'b0;
    settle();
    check("af_vc0_after", {30'd0, vc0_pop, vc1_pop}, 32'd2);
    sb.push_back(6'h1A);
    tick();
    vc0_empty = 1'b1;
    tick(); tick(); tick();
    check("back_idle_3", {31'd0, idle_out}, 32'd1);

    // init during traffic
    vc0_empty = 1'b0; vc0_data = 6'h07;
    tick();
    settle();
    check("init_pre_pop", {30'd0, vc0_pop, vc1_pop}, 32'd2);
    sb.push_back(6'h07);
    tick();
    init = 1'b1;
    settle();
    check("init_no_pop", {30'd0, vc0_pop, vc1_pop}, 32'd0);
    tick();
    check("init_state", {28'd0, idle_out, active_out, error_out, d0_push}, 32'd0);
    settle();
    check("init_hold_pop", {30'd0, vc0_pop, vc1_pop}, 32'd0);
    init = 1'b0;
    tick();
    check("init_rel_idle", {31'd0, idle_out}, 32'd1);
    settle();
    check("init_rel_nopop", {30'd0, vc0_pop, vc1_pop}, 32'd0);
    tick();
    check("init_rel_active", {31'd0, active_out}, 32'd1);
    settle();
    check("init_rel_pop", {30'd0, vc0_pop, vc1_pop}, 32'd2);
    sb.push_back(6'h07);
    tick();

    // push into a full D0 -> ERROR, sticky
    vc0_data = 6'h0C; d0_full = 1'b1;
    settle();
    check("err_pop", {30'd0, vc0_pop, vc1_pop}, 32'd2);
    tick();
    check("err_enter", {29'd0, error_out, active_out, d0_push}, 32'd4);
    d0_full = 1'b0;
    settle();
    check("err_no_pop", {30'd0, vc0_pop, vc1_pop}, 32'd0);
    init = 1'b1;
    tick(); tick();
    init = 1'b0;
    tick();
    check("err_sticky", {28'd0, error_out, idle_out, active_out, d0_push}, 32'd8);
    settle();
    check("err_sticky_pop", {30'd0, vc0_pop, vc1_pop}, 32'd0);

    // reset clears ERROR; reset during a grant discards the push
    reset = 1'b1;
    tick();
    check("reset_clr_err", {29'd0, error_out, idle_out, active_out}, 32'd0);
    reset = 1'b0; vc0_data = 6'h09;
    tick(); tick(); tick();
    check("rst2_active", {31'd0, active_out}, 32'd1);
    settle();
    check("rst2_pop", {30'd0, vc0_pop, vc1_pop}, 32'd2);
    reset = 1'b1;
    tick();
    check("rst2_discard", {30'd0, d0_push, d1_push}, 32'd0);
    reset = 1'b0; vc0_empty = 1'b1;
    tick(); tick();

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
